// File: rtl/mult8_share_arbiter.sv
// Round-robin arbiter sharing one 8x8 unsigned Wallace-tree multiplier across NUM_REQ requesters.
// Define MULT8_SHARE_ARBITER_STATS_EN to add per-requester saturating grant counters.

module multiply8_unsigned_wallace_tree (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);

  logic [15:0] pp [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
      assign pp[gi] = {8'd0, a & {8{b[gi]}}} << gi;
    end
  endgenerate

  // Word-level 3:2 compressors; the product fits in 16 bits so carries past bit 15 are always zero.
  function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] l1_s0, l1_c0, l1_s1, l1_c1;
  logic [15:0] l2_s0, l2_c0, l2_s1, l2_c1;
  logic [15:0] l3_s0, l3_c0;
  logic [15:0] l4_s0, l4_c0;

  // Layer 1: 8 rows -> 6 rows
  assign l1_s0 = csa_sum  (pp[0], pp[1], pp[2]);
  assign l1_c0 = csa_carry(pp[0], pp[1], pp[2]);
  assign l1_s1 = csa_sum  (pp[3], pp[4], pp[5]);
  assign l1_c1 = csa_carry(pp[3], pp[4], pp[5]);

  // Layer 2: 6 rows -> 4 rows
  assign l2_s0 = csa_sum  (l1_s0, l1_c0, l1_s1);
  assign l2_c0 = csa_carry(l1_s0, l1_c0, l1_s1);
  assign l2_s1 = csa_sum  (l1_c1, pp[6], pp[7]);
  assign l2_c1 = csa_carry(l1_c1, pp[6], pp[7]);

  // Layer 3: 4 rows -> 3 rows
  assign l3_s0 = csa_sum  (l2_s0, l2_c0, l2_s1);
  assign l3_c0 = csa_carry(l2_s0, l2_c0, l2_s1);

  // Layer 4: 3 rows -> 2 rows, then the final carry-propagate add
  assign l4_s0 = csa_sum  (l3_s0, l3_c0, l2_c1);
  assign l4_c0 = csa_carry(l3_s0, l3_c0, l2_c1);

  assign product = l4_s0 + l4_c0;

endmodule

module mult8_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_product,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
`ifdef MULT8_SHARE_ARBITER_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NUM_REQ*16-1:0]  grant_cnt
`endif
);

  logic [7:0]      a_reg, b_reg;
  logic [ID_W-1:0] id_reg;
  logic            s1_valid_reg;
  logic [15:0]     product_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic            s2_valid_reg;
  logic [ID_W-1:0] rr_ptr_reg;

  logic            s1_adv, s2_adv;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            handshake;
  logic [ID_W-1:0] rr_ptr_next;
  logic [7:0]      grant_a, grant_b;
  logic [15:0]     mult_product;

  assign s2_adv = !s2_valid_reg || rsp_ready;
  assign s1_adv = !s1_valid_reg || s2_adv;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = s1_adv && grant_found && (grant_idx == ID_W'(gi));
    end
  endgenerate

  assign handshake   = s1_adv && grant_found;
  assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_a     = req_a[8*grant_idx +: 8];
  assign grant_b     = req_b[8*grant_idx +: 8];

  multiply8_unsigned_wallace_tree u_mult (
    .a       (a_reg),
    .b       (b_reg),
    .product (mult_product)
  );

  // Stage 1: operand registers and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      id_reg       <= '0;
      s1_valid_reg <= 1'b0;
      rr_ptr_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= handshake;
      if (handshake) begin
        a_reg      <= grant_a;
        b_reg      <= grant_b;
        id_reg     <= grant_idx;
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  // Stage 2: result registers drive the response port directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg  <= '0;
      rsp_id_reg   <= '0;
      s2_valid_reg <= 1'b0;
    end else if (s2_adv) begin
      product_reg  <= mult_product;
      rsp_id_reg   <= id_reg;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  assign rsp_valid   = s2_valid_reg;
  assign rsp_product = product_reg;
  assign rsp_id      = rsp_id_reg;
  assign busy        = s1_valid_reg || s2_valid_reg;

`ifdef MULT8_SHARE_ARBITER_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] cnt_reg;
      // Clear has priority over a same-cycle grant.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (stats_clr) begin
          cnt_reg <= '0;
        end else if (req_ready[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign grant_cnt[16*gi +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mult8_share_arbiter.sv
// Randomized + directed bench for mult8_share_arbiter against a queue-based reference model.
// Build with MULT8_SHARE_ARBITER_STATS_EN defined to also exercise the grant counters.

module tb_mult8_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [8*NUM_REQ-1:0]  req_a;
  logic [8*NUM_REQ-1:0]  req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_product;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
  logic                  stats_clr;
`ifdef MULT8_SHARE_ARBITER_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  mult8_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
`ifdef MULT8_SHARE_ARBITER_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .grant_cnt   (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight entries in order, with the edge at which each was accepted.
  typedef struct {
    int id;
    int prod;
    int stamp;
  } ent_t;

  ent_t q[$];
  int   ptr;
  int   edges;
  int   stat_cnt[NUM_REQ];
  int   g_last;
  int   fires;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] = 0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]    = v;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  // One clock: check outputs at negedge against the model, then advance the model past posedge.
  task automatic run_cycle();
    int g;
    bit vis;
    bit fire;
    logic [NUM_REQ-1:0] exp_ready;
    logic [7:0] ga, gb;
    @(negedge clk);
    vis  = (q.size() > 0) && (q[0].stamp < edges);
    fire = vis && rsp_ready;
    g = -1;
    if (q.size() < 2 || fire) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && req_valid[(ptr + k) % NUM_REQ]) g = (ptr + k) % NUM_REQ;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(vis));
    check("busy", 32'(busy), 32'(q.size() > 0));
    if (vis) begin
      check("rsp_product", 32'(rsp_product), 32'(q[0].prod));
      check("rsp_id", 32'(rsp_id), 32'(q[0].id));
    end
`ifdef MULT8_SHARE_ARBITER_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      check("grant_cnt", 32'(grant_cnt[16*i +: 16]), 32'(stat_cnt[i]));
`endif
    ga = 8'd0;
    gb = 8'd0;
    if (g >= 0) begin
      ga = req_a[8*g +: 8];
      gb = req_b[8*g +: 8];
    end
    @(posedge clk);
    #1;
    edges++;
    if (fire) begin
      void'(q.pop_front());
      fires++;
    end
    if (g >= 0) begin
      q.push_back('{id: g, prod: int'(ga) * int'(gb), stamp: edges});
      ptr = (g + 1) % NUM_REQ;
    end
    if (stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] = 0;
    end else if (g >= 0 && stat_cnt[g] < 65535) begin
      stat_cnt[g]++;
    end
    g_last = g;
  endtask

  task automatic do_reset();
    req_valid = '0;
    stats_clr = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(rsp_product), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[6];
    int accepts;
    int fires_before;
    checks    = 0;
    errors    = 0;
    edges     = 0;
    fires     = 0;
    g_last    = -1;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    stats_clr = 1'b0;
    model_reset();

    // Single operation with the largest operands
    do_reset();
    set_req(0, 1'b1, 8'd255, 8'd255);
    run_cycle();
    check("single_grant", 32'(g_last), 32'd0);
    req_valid = '0;
    run_cycle();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_product", 32'(rsp_product), 32'hFE01);
    check("single_id", 32'(rsp_id), 32'd0);
    run_cycle();
    check("single_idle", 32'(busy), 32'd0);

    // Round-robin with all requesters continuously valid
    do_reset();
    rr_exp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(i + 1), 8'd3);
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      check("rr_grant", 32'(g_last), 32'(rr_exp[k]));
      if (k > 0) begin
        check("rr_product", 32'(rsp_product), 32'((rr_exp[k-1] + 1) * 3));
        check("rr_id", 32'(rsp_id), 32'(rr_exp[k-1]));
      end
    end
    req_valid = '0;
    repeat (3) run_cycle();

    // Backpressure: stall the consumer while requester 2 streams
    do_reset();
    rsp_ready = 1'b0;
    accepts   = 0;
    set_req(2, 1'b1, rand_op(), rand_op());
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      if (g_last == 2) begin
        accepts++;
        set_req(2, 1'b1, rand_op(), rand_op());
      end
    end
    check("bp_accepts", 32'(accepts), 32'd2);
    req_valid    = '0;
    rsp_ready    = 1'b1;
    fires_before = fires;
    repeat (4) run_cycle();
    check("bp_drained", 32'(fires - fires_before), 32'd2);

    // Pointer wrap: move rr_ptr to 3, then requesters 3 and 0 compete
    do_reset();
    set_req(2, 1'b1, 8'd10, 8'd11);
    run_cycle();
    check("wrap_setup", 32'(g_last), 32'd2);
    req_valid = '0;
    set_req(3, 1'b1, 8'd20, 8'd21);
    set_req(0, 1'b1, 8'd30, 8'd31);
    run_cycle();
    check("wrap_grant3", 32'(g_last), 32'd3);
    run_cycle();
    check("wrap_grant0", 32'(g_last), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(i), 8'd5);
    run_cycle();
    check("wrap_ptr1", 32'(g_last), 32'd1);
    req_valid = '0;
    repeat (3) run_cycle();

    // Asynchronous reset with both stages occupied
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'd9, 8'd9);
    repeat (3) run_cycle();
    req_valid = '0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    do_reset();
    rsp_ready = 1'b1;
    repeat (3) run_cycle();

`ifdef MULT8_SHARE_ARBITER_STATS_EN
    // Grant counters: three ops, then clear coinciding with a fourth
    do_reset();
    set_req(1, 1'b1, 8'd7, 8'd9);
    repeat (3) run_cycle();
    check("stats_three", 32'(grant_cnt[31:16]), 32'd3);
    stats_clr = 1'b1;
    run_cycle();
    stats_clr = 1'b0;
    check("stats_clr_grant", 32'(g_last), 32'd1);
    check("stats_cleared", 32'(grant_cnt[31:16]), 32'd0);
    req_valid = '0;
    repeat (3) run_cycle();
`endif

    // Randomized traffic with random backpressure
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      stats_clr = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g_last == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 1'b1, rand_op(), rand_op());
      end
      run_cycle();
    end
    stats_clr = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) run_cycle();
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
